// File: rtl/in_debounce_pkg.sv
// Shared types and defaults for the two-channel input debouncer.
package in_debounce_pkg;

    // Per-channel debounce FSM state
    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_t;

    localparam int unsigned DB_SYNC_STAGES_DEF   = 2;
    localparam int unsigned DB_STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/in_debounce2_ch.sv
// debounce_ch: synchroniser, stability counter and level FSM for one channel.
// Optional macro IN_DEBOUNCE2_EDGE_PULSE_EN adds the rise_o pulse output.
module debounce_ch
    import in_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DB_SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic settled_o
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
    ,
    output logic rise_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    db_state_t              state_q;
    db_state_t              state_d;

    // Shift the raw level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // State and stability counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count consecutive cycles the synced level disagrees with the output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LO: begin
                cnt_d = '0;
                if (synced) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!synced) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                cnt_d = '0;
                if (!synced) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (synced) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode directly from the registered state
    always_comb begin
        level_o   = (state_q == ST_HI) || (state_q == ST_WAIT_LO);
        settled_o = (state_q == ST_LO) || (state_q == ST_HI);
    end

`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
    // Pulse alongside the first cycle the output reads high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_o <= 1'b0;
        end else begin
            rise_o <= (state_d == ST_HI) &&
                      ((state_q == ST_LO) || (state_q == ST_WAIT_HI));
        end
    end
`endif

endmodule

// File: rtl/in_debounce2.sv
// in_debounce2: two independent debounced channels feeding a 2-input AND stage.
// Optional macro IN_DEBOUNCE2_EDGE_PULSE_EN adds a_rise/b_rise pulse outputs.
module in_debounce2
    import in_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DB_SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    // Derived from STABLE_CYCLES; leave at its default
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_o,
    output logic b_o,
    output logic stable
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
    ,
    output logic a_rise,
    output logic b_rise
`endif
);

    logic a_settled;
    logic b_settled;

    debounce_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_ch_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    (a_raw),
        .level_o  (a_o),
        .settled_o(a_settled)
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
        ,
        .rise_o   (a_rise)
`endif
    );

    debounce_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_ch_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    (b_raw),
        .level_o  (b_o),
        .settled_o(b_settled)
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
        ,
        .rise_o   (b_rise)
`endif
    );

    // Both settle flags come straight from state registers, so stable follows the state edge
    assign stable = a_settled & b_settled;

endmodule

// File: tb/tb_in_debounce2.sv
// Self-checking bench for in_debounce2 against a windowed history model.
module tb_in_debounce2;

    localparam int SYNC = 2;
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
    localparam int STB = 1;
`else
    localparam int STB = 4;
`endif
    localparam int HL = SYNC + STB;

    logic clk = 1'b0;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_o;
    logic b_o;
    logic stable;
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
    logic a_rise;
    logic b_rise;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    always #5 clk = ~clk;

    in_debounce2 #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a_o   (a_o),
        .b_o   (b_o),
        .stable(stable)
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
        ,
        .a_rise(a_rise),
        .b_rise(b_rise)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Edge counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: output flips when the last STB synced samples all differ from it;
    // the synced sample seen at an edge is the raw value captured SYNC edges earlier.
    bit       hist [2][HL];
    bit [1:0] m_out    = '0;
    bit [1:0] m_rise   = '0;
    bit       m_stable = 1'b1;
    bit       all_diff;
    bit [1:0] settled;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < HL; i++) hist[ch][i] = 1'b0;
            end
            m_out    = '0;
            m_rise   = '0;
            m_stable = 1'b1;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = HL - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
                hist[ch][0] = (ch == 0) ? a_raw : b_raw;
                all_diff = 1'b1;
                for (int j = 0; j < STB; j++) begin
                    if (hist[ch][SYNC+j] == m_out[ch]) all_diff = 1'b0;
                end
                m_rise[ch] = all_diff && !m_out[ch];
                if (all_diff) m_out[ch] = ~m_out[ch];
                settled[ch] = (hist[ch][SYNC] == m_out[ch]);
            end
            m_stable = &settled;
        end
    end

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_o", a_o, m_out[0]);
            chk("b_o", b_o, m_out[1]);
            chk("stable", stable, m_stable);
`ifdef IN_DEBOUNCE2_EDGE_PULSE_EN
            chk("a_rise", a_rise, m_rise[0]);
            chk("b_rise", b_rise, m_rise[1]);
`endif
        end
    end

    // Record rising edges of the debounced outputs
    int   rises_a = 0, rises_b = 0;
    int   last_rise_a = -1, last_rise_b = -1;
    logic pa = 1'b0, pb = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (a_o === 1'b1 && pa !== 1'b1) begin rises_a++; last_rise_a = cyc; end
        if (b_o === 1'b1 && pb !== 1'b1) begin rises_b++; last_rise_b = cyc; end
        pa = a_o;
        pb = b_o;
    end

    // Downstream AND stage stand-in
    logic and_q = 1'b0;
    always @(posedge clk) and_q <= a_o & b_o;

    int c, c2, r0;
    int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int hold_a, hold_b;

    initial begin
        rst_n = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (3) tick;
        chk_en = 1'b1;
        chk("reset a_o", a_o, 0);
        chk("reset b_o", b_o, 0);
        chk("reset stable", stable, 1);
        rst_n = 1'b1;
        repeat (4) tick;

`ifndef IN_DEBOUNCE2_EDGE_PULSE_EN
        // a_raw held high: capture at c+1, output at c+6
        c = cyc;
        a_raw = 1'b1;
        repeat (3) tick;
        chk("t1 stable pending", stable, 0);
        chk("t1 a_o early", a_o, 0);
        repeat (2) tick;
        chk("t1 a_o before", a_o, 0);
        tick;
        chk("t1 a_o rise", a_o, 1);
        chk("t1 rise edge", last_rise_a, c + 6);
        chk("t1 stable back", stable, 1);

        // Short pulse on b is rejected
        r0 = rises_b;
        b_raw = 1'b1;
        repeat (3) tick;
        b_raw = 1'b0;
        repeat (8) tick;
        chk("t2 b_o", b_o, 0);
        chk("t2 stable", stable, 1);
        chk("t2 b rises", rises_b, r0);

        // Bouncing a: single rise 5 edges after the final 0->1 capture
        a_raw = 1'b0;
        repeat (10) tick;
        r0 = rises_a;
        c = cyc;
        for (int i = 0; i < 9; i++) begin
            a_raw = pat[i][0];
            tick;
        end
        a_raw = 1'b1;
        repeat (10) tick;
        chk("t3 rise count", rises_a - r0, 1);
        chk("t3 rise edge", last_rise_a, c + 11);

        // Simultaneous switch on both channels
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (10) tick;
        c = cyc;
        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (6) tick;
        chk("t4 a rise edge", last_rise_a, c + 6);
        chk("t4 b rise edge", last_rise_b, c + 6);
        chk("t4 and early", and_q, 0);
        tick;
        chk("t4 and late", and_q, 1);

        // Reset mid-count discards the pending rise
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (10) tick;
        a_raw = 1'b1;
        repeat (4) tick;
        chk("t5 stable counting", stable, 0);
        rst_n = 1'b0;
        #1;
        chk("t5 a_o in reset", a_o, 0);
        chk("t5 stable in reset", stable, 1);
        tick;
        rst_n = 1'b1;
        c2 = cyc;
        repeat (5) tick;
        chk("t5 a_o before", a_o, 0);
        tick;
        chk("t5 a_o after", a_o, 1);
        chk("t5 rise edge", last_rise_a, c2 + 6);
`else
        // STABLE_CYCLES=1: rise at capture+2, pulse for one cycle, none on the fall
        a_raw = 1'b0;
        repeat (4) tick;
        c = cyc;
        a_raw = 1'b1;
        repeat (2) tick;
        chk("p1 a_o before", a_o, 0);
        tick;
        chk("p1 a_o", a_o, 1);
        chk("p1 a_rise", a_rise, 1);
        tick;
        chk("p1 a_rise cleared", a_rise, 0);
        a_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("p1 no fall pulse", a_rise, 0);
        end
        chk("p1 a_o fell", a_o, 0);
`endif

        // Randomised run-lengths with occasional resets
        hold_a = 0;
        hold_b = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_a == 0) begin
                a_raw  = 1'($urandom_range(0, 1));
                hold_a = int'($urandom_range(1, 7));
            end
            if (hold_b == 0) begin
                b_raw  = 1'($urandom_range(0, 1));
                hold_b = int'($urandom_range(1, 7));
            end
            hold_a--;
            hold_b--;
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            tick;
            rst_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/in_debounce2.md
Name: in_debounce2

Overview:
- Two-channel input conditioning stage that sits directly upstream of the 2-input AND gate stage.
- Takes raw, asynchronous, possibly bouncing switch inputs `a_raw` and `b_raw`. Synchronises each to `clk`, debounces it with a per-channel counter FSM, and drives clean registered levels `a_o` and `b_o`.
- `a_o` and `b_o` connect straight to the AND stage's `a` and `b` inputs.

Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops per channel. Legal values are 2 or more.
- `STABLE_CYCLES`, default 4: consecutive cycles that the synced input must differ from the current output before the output flips. Legal values are 1 or more.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: debounce counter width. It is derived and must not be overridden.

Ports:
- `clk`, input, 1: single clock. All state is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `a_raw`, input, 1: raw asynchronous input, channel A.
- `b_raw`, input, 1: raw asynchronous input, channel B.
- `a_o`, output, 1: debounced level, channel A. Feeds the AND stage input `a`.
- `b_o`, output, 1: debounced level, channel B. Feeds the AND stage input `b`.
- `stable`, output, 1: high when both channels are settled, i.e. no pending transition.

Behaviour:
- Reset (`rst_n`=0, asynchronous): every synchroniser flop, counter and output is cleared to 0. Both FSMs go to `ST_LO`, so `a_o`=0, `b_o`=0, `stable`=1.
  - Reset asserted mid-count discards the pending transition.
- Synchroniser: a `SYNC_STAGES`-deep shift chain per channel. The last stage is "synced".
- Per-channel FSM states:
  - `ST_LO` (output 0)
  - `ST_WAIT_HI` (output 0, counting)
  - `ST_HI` (output 1)
  - `ST_WAIT_LO` (output 1, counting)
- Transitions, evaluated each cycle:
  - `ST_LO`: synced=1 with `STABLE_CYCLES`=1 → `ST_HI` and the output flips. Synced=1 otherwise → `ST_WAIT_HI`, cnt=1. Synced=0 → stay.
  - `ST_WAIT_HI`: synced=0 → `ST_LO`, cnt=0 (glitch rejected). Synced=1 and cnt==`STABLE_CYCLES`-1 → `ST_HI`, output=1, cnt=0. Synced=1 otherwise → cnt+1.
  - `ST_HI` and `ST_WAIT_LO`: mirror images of the above.
- Latency: raw level first captured at edge k → output changes at edge k+`SYNC_STAGES`+`STABLE_CYCLES`-1. With defaults this is edge k+5.
- Glitch rejection: any synced pulse shorter than `STABLE_CYCLES` cycles never reaches the output.
- Outputs are registered, so there is no combinational path from `a_raw`/`b_raw` to any output.
- The counter never exceeds `STABLE_CYCLES`-1, so there is no wrap-around.
- `stable` = both FSMs in `ST_LO` or `ST_HI`. It is registered, updates on the same edge as the state, and reset value is 1.
- Channels are fully independent. Simultaneous changes on A and B flip both outputs on the same edge.
- After reset release with a raw input held at 1, that output rises after the normal latency.

Optional Feature:
- Macro: `IN_DEBOUNCE2_EDGE_PULSE_EN`.
- Defined: adds two 1-bit outputs, `a_rise` and `b_rise`.
  - Each is a single-cycle registered pulse, high in the cycle immediately after its output flips 0→1.
  - Both reset to 0.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Package `in_debounce_pkg` holds:
  - the 2-bit state typedef `db_state_t` with `ST_LO`=0, `ST_WAIT_HI`=1, `ST_HI`=2, `ST_WAIT_LO`=3;
  - constants `DB_SYNC_STAGES_DEF`=2 and `DB_STABLE_CYCLES_DEF`=4.
- One sub-module, `debounce_ch`: synchroniser, counter and FSM for a single channel.
  - Instantiated twice.
  - Exposes `level_o`, `settled_o`, and a `rise_o` port that is only present when the macro is defined.

Test Plan:
- Reset then `a_raw`=1 held, defaults, first capture at edge 10 → `a_o` rises at edge 15; `stable`=0 during edges 12–14 and back to 1 at edge 15.
- `b_raw` 3-cycle pulse, `STABLE_CYCLES`=4 → `b_o` stays 0, and `stable` returns to 1 once the pulse clears the synchroniser.
- Bouncing `a_raw` pattern 1,0,1,1,0,1,1,1,1 followed by steady 1 → exactly one `a_o` rise, 5 edges after the final 0→1 capture.
- `a_raw` and `b_raw` both switched to 1 on the same edge → `a_o` and `b_o` rise on the same edge; the downstream AND output goes 1 one stage later.
- `rst_n` pulsed low during `ST_WAIT_HI` (cnt=2) → `a_o`=0 immediately; after release the count restarts from 0, and with `a_raw` held at 1 `a_o` rises 5 edges after the first post-reset capture.
- With `IN_DEBOUNCE2_EDGE_PULSE_EN` defined and `STABLE_CYCLES`=1 → `a_rise` is high for exactly one cycle after `a_o` goes 0→1, and there is no pulse on the 1→0 transition.
